// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   IFB_WIDTH      width of one fetch-buffer entry
//   FETCH_VALID    status code of a clean fetch
//   FETCH_BUSERR   status code of a fetch answered with a bus error
//   htrans_e       AHB-Lite transfer types used by the fetch unit
//   secded_encode  7-bit SECDED check bits over a 32-bit word
package ifu_fetch_pkg;

  localparam int unsigned IFB_WIDTH = 38;

  localparam logic [2:0] FETCH_VALID  = 3'b001;
  localparam logic [2:0] FETCH_BUSERR = 3'b010;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

  // Extended Hamming(39,32): data bits sit at the non-power-of-two codeword positions 3..38,
  // check bit b covers every position whose index has bit b set; bit 6 is overall parity.
  function automatic logic [6:0] secded_encode(input logic [31:0] data);
    logic [6:0]  chk;
    logic [5:0]  pos;
    int unsigned idx;
    chk = '0;
    idx = 0;
    for (int unsigned p = 3; p <= 38; p++) begin
      pos = 6'(p);
      if ((pos & (pos - 6'd1)) != 6'd0) begin
        for (int unsigned b = 0; b < 6; b++) begin
          if (pos[b]) chk[b] = chk[b] ^ data[idx];
        end
        idx++;
      end
    end
    chk[6] = ^{data, chk[5:0]};
    return chk;
  endfunction

endpackage

// File: rtl/ifu_credit.sv
// Issue credit for the fetch unit: a new fetch may start only if every fetch already
// in flight plus every occupied buffer entry still leaves room in the fetch buffer.
//   s_occupied_i  per-entry occupancy of the fetch buffer
//   s_inflight_i  fetches accepted by the bus but not yet completed
//   s_allow_o     1 when a new fetch may be issued
module ifu_credit #(
  parameter int unsigned IFB_SIZE = 2
) (
  input  logic [IFB_SIZE-1:0] s_occupied_i,
  input  logic [1:0]          s_inflight_i,
  output logic                s_allow_o
);

  always_comb begin
    int unsigned used_cnt;
    used_cnt = 32'(s_inflight_i);
    for (int unsigned i = 0; i < IFB_SIZE; i++) begin
      used_cnt = used_cnt + 32'(s_occupied_i[i]);
    end
    // Pops in this cycle are not credited back; the bound stays conservative.
    s_allow_o = (used_cnt < IFB_SIZE);
  end

endmodule

// File: rtl/seu_regs.sv
// Generic state register bank with asynchronous active-low reset.
//   s_c_i       clock
//   s_resetn_i  asynchronous active-low reset, loads RST_VAL
//   s_d_i       next state
//   s_d_o       current state
module seu_regs #(
  parameter string       LABEL   = "SEU",
  parameter int unsigned N       = 1,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic         s_c_i,
  input  logic         s_resetn_i,
  input  logic [N-1:0] s_d_i,
  output logic [N-1:0] s_d_o
);

  logic [N-1:0] regs_q;

  always_ff @(posedge s_c_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      regs_q <= RST_VAL;
    end else begin
      regs_q <= s_d_i;
    end
  end

  assign s_d_o = regs_q;

  // The label only names the instance for fault-injection tooling; no logic depends on it.
  if (LABEL == "") begin : g_unlabelled
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: walks the PC sequentially, drives pipelined AHB-Lite reads and
// pushes each completed response, tagged with a fetch status, into the fetch buffer.
//   s_clk_i / s_resetn_i   clock, asynchronous active-low reset
//   s_flush_i              redirect; discards every in-flight fetch
//   s_flush_addr_i         redirect target (bits [1:0] ignored)
//   s_ifb_occupied_i       fetch-buffer occupancy, used for issue credit
//   s_hrdata_i/s_hready_i/s_hresp_i   AHB-Lite response
//   s_haddr_o/s_htrans_o   AHB-Lite address phase
//   s_push_o/s_data_o      fetch-buffer write port
//   s_checksum_o           SECDED bits of s_data_o[31:0] (EDAC_INTERFACE builds only)
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int unsigned IFB_SIZE  = 2,
  parameter string       LABEL     = "IFU"
) (
  input  logic                 s_clk_i,
  input  logic                 s_resetn_i,
  input  logic                 s_flush_i,
  input  logic [31:0]          s_flush_addr_i,
  input  logic [IFB_SIZE-1:0]  s_ifb_occupied_i,
  input  logic [31:0]          s_hrdata_i,
  input  logic                 s_hready_i,
  input  logic                 s_hresp_i,
  output logic [31:0]          s_haddr_o,
  output logic [1:0]           s_htrans_o,
  output logic                 s_push_o,
  output logic [IFB_WIDTH-1:0] s_data_o
`ifdef EDAC_INTERFACE
  ,
  output logic [6:0]           s_checksum_o
`endif
);

  localparam int unsigned StateW = 37;

  logic [31:0] pc_q, pc_d;
  logic        aphase_valid_q, aphase_valid_d;
  logic        dphase_valid_q, dphase_valid_d;
  logic        dphase_kill_q, dphase_kill_d;
  logic [1:0]  inflight_q, inflight_d;
  logic [StateW-1:0] state_q, state_d;

  logic credit_ok;
  logic issue;
  logic accept;
  logic complete;
  logic unused_flush_lsb;

  assign unused_flush_lsb = ^s_flush_addr_i[1:0];

  ifu_credit #(
    .IFB_SIZE(IFB_SIZE)
  ) u_credit (
    .s_occupied_i(s_ifb_occupied_i),
    .s_inflight_i(inflight_q),
    .s_allow_o   (credit_ok)
  );

  always_comb begin
    // A NONSEQ stalled by hready=0 stays on the bus even if credit has since changed.
    issue    = s_resetn_i & ~s_flush_i & (aphase_valid_q | credit_ok);
    accept   = issue & s_hready_i;
    complete = dphase_valid_q & s_hready_i;

    pc_d = pc_q;
    if (s_flush_i) begin
      pc_d = {s_flush_addr_i[31:2], 2'b00};
    end else if (accept) begin
      pc_d = pc_q + 32'd4;
    end

    aphase_valid_d = issue & ~s_hready_i;
    dphase_valid_d = s_hready_i ? accept : dphase_valid_q;
    // Kill sticks to a stalled data phase until it completes; a flush marks whatever is pending.
    dphase_kill_d  = dphase_valid_d & (s_flush_i | (~s_hready_i & dphase_kill_q));
    inflight_d     = inflight_q + {1'b0, accept} - {1'b0, complete};
  end

  always_comb begin
    s_push_o = complete & ~dphase_kill_q & ~s_flush_i;
    s_data_o = '0;
    if (s_push_o) begin
      s_data_o = {2'b00, (s_hresp_i ? FETCH_BUSERR : FETCH_VALID), 1'b0, s_hrdata_i};
    end
  end

  assign s_htrans_o = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign s_haddr_o  = pc_q;

`ifdef EDAC_INTERFACE
  assign s_checksum_o = secded_encode(s_data_o[31:0]);
`endif

  assign state_d = {pc_d, aphase_valid_d, dphase_valid_d, dphase_kill_d, inflight_d};

  seu_regs #(
    .LABEL  (LABEL),
    .N      (StateW),
    .RST_VAL({BOOT_ADDR, 5'b00000})
  ) u_state (
    .s_c_i     (s_clk_i),
    .s_resetn_i(s_resetn_i),
    .s_d_i     (state_d),
    .s_d_o     (state_q)
  );

  assign pc_q           = state_q[36:5];
  assign aphase_valid_q = state_q[4];
  assign dphase_valid_q = state_q[3];
  assign dphase_kill_q  = state_q[2];
  assign inflight_q     = state_q[1:0];

endmodule
